// File: rtl/pb_irq_pkg.sv
// Purpose : shared constants for the PicoBlaze interrupt controller slice.
// Latency : n/a (package only).
// Backpr. : n/a.
// Contents: port addresses 0x10..0x13, FSM state encoding, source/vector widths,
//           one-hot helper. Optional build macro used by the slice: IRQ_RR_EN.
package pb_irq_pkg;

    localparam logic [7:0] ADDR_VEC  = 8'h10;
    localparam logic [7:0] ADDR_MASK = 8'h11;
    localparam logic [7:0] ADDR_PEND = 8'h12;
    localparam logic [7:0] ADDR_TDIV = 8'h13;

    localparam int MAX_SRC = 8;
    localparam int VEC_W   = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    function automatic logic [MAX_SRC-1:0] vec_onehot(input logic [VEC_W-1:0] v);
        vec_onehot = '0;
        vec_onehot[v] = 1'b1;
    endfunction

endpackage

// File: rtl/pb_irq_ctrl_tick_gen.sv
// Purpose : programmable periodic tick, prescaler (0..TICK_PRE-1) then divider (0..div).
// Latency : tick is registered, high the cycle after the divider wraps; expire is the
//           same-cycle combinational wrap indication.  Backpr.: none, free running.
// Ports   : clk, rst (sync, active-high), div (divider terminal value), reload (zero both
//           counters this edge), tick (1-cycle pulse), expire (wrap happens this edge).
module irq_tick_gen #(
    parameter int TICK_PRE = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] div,
    input  logic       reload,
    output logic       tick,
    output logic       expire
);
    localparam int PRE_W = (TICK_PRE > 1) ? $clog2(TICK_PRE) : 1;

    logic [PRE_W-1:0] pre_cnt;
    logic [7:0]       div_cnt;
    logic             pre_wrap;

    assign pre_wrap = (pre_cnt == PRE_W'(TICK_PRE - 1));
    // A reload on the same edge wins over an expiry: the period restarts cleanly.
    assign expire   = pre_wrap && (div_cnt == div) && !reload;

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            pre_cnt <= '0;
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= expire;
            if (pre_wrap) begin
                pre_cnt <= '0;
                div_cnt <= (div_cnt == div) ? 8'd0 : div_cnt + 8'd1;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end
endmodule

// File: rtl/pb_irq_ctrl.sv
// Purpose : PicoBlaze interrupt controller: pending/mask registers, one winner per
//           interrupt/ack handshake, port-mapped VEC/MASK/PEND/TICK_DIV, internal tick.
// Latency : rd_data/rd_hit 1 cycle after port_id; interrupt 1 cycle after pend&mask.
// Backpr. : none; KCPSM6 paces service with interrupt_ack.
// Ports   : src_evt (rising-edge events, bit i -> source i+1), PicoBlaze port bus,
//           interrupt/interrupt_ack handshake, tick pulse.
// Build   : define IRQ_RR_EN for round-robin arbitration, otherwise lowest index wins.
module pb_irq_ctrl
    import pb_irq_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int TICK_PRE     = 500000,
    parameter int TICK_DIV_RST = 99
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-2:0] src_evt,
    input  logic [7:0]         port_id,
    input  logic [7:0]         out_port,
    input  logic               write_strobe,
    input  logic               read_strobe,
    output logic [7:0]         rd_data,
    output logic               rd_hit,
    output logic               interrupt,
    input  logic               interrupt_ack,
    output logic               tick
);
    logic [NUM_SRC-1:0] mask, pend, pm, pend_set, pend_clr, w1c, ack_clr;
    logic [NUM_SRC-2:0] src_q;
    logic [7:0]         tdiv;
    logic [1:0]         state;
    logic [VEC_W-1:0]   vec, winner;
    logic               valid, expire, ack_take;
    logic [MAX_SRC-1:0] win_oh;
    logic [7:0]         mask8, pend8, rd_nxt;

    wire wr_mask = write_strobe && (port_id == ADDR_MASK);
    wire wr_pend = write_strobe && (port_id == ADDR_PEND);
    wire wr_tdiv = write_strobe && (port_id == ADDR_TDIV);

    irq_tick_gen #(.TICK_PRE(TICK_PRE)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .div    (tdiv),
        .reload (wr_tdiv),
        .tick   (tick),
        .expire (expire)
    );

    assign pm       = pend & mask;
    assign ack_take = (state == ST_REQ) && (|pm) && interrupt_ack;
    assign win_oh   = vec_onehot(winner);
    assign ack_clr  = ack_take ? win_oh[NUM_SRC-1:0] : '0;
    assign w1c      = wr_pend ? out_port[NUM_SRC-1:0] : '0;
    assign pend_set = {src_evt & ~src_q, expire};
    assign pend_clr = w1c | ack_clr;

`ifdef IRQ_RR_EN
    logic [VEC_W-1:0] rr_ptr;
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        // Walk downward so the candidate nearest to rr_ptr+1 is the last one written.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + 1 + k) % NUM_SRC;
            if (pm[idx]) winner = VEC_W'(idx);
        end
    end
    always_ff @(posedge clk) begin
        if (rst)           rr_ptr <= VEC_W'(NUM_SRC - 1);
        else if (ack_take) rr_ptr <= winner;
    end
`else
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pm[i]) winner = VEC_W'(i);
        end
    end
`endif

    // Pending, mask, divider and edge history. Set is applied after clear so a
    // simultaneous event survives an ack or W1C of the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend  <= '0;
            mask  <= NUM_SRC'(1);
            tdiv  <= 8'(TICK_DIV_RST);
            src_q <= '1;
        end else begin
            pend  <= (pend & ~pend_clr) | pend_set;
            src_q <= src_evt;
            if (wr_mask) mask <= out_port[NUM_SRC-1:0];
            if (wr_tdiv) tdiv <= out_port;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            interrupt <= 1'b0;
            vec       <= '0;
            valid     <= 1'b0;
        end else begin
            if (read_strobe && (port_id == ADDR_VEC)) valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|pm) begin
                        state     <= ST_REQ;
                        interrupt <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (!(|pm)) begin
                        state     <= ST_IDLE;
                        interrupt <= 1'b0;
                    end else if (interrupt_ack) begin
                        vec       <= winner;
                        valid     <= 1'b1;
                        interrupt <= 1'b0;
                        state     <= ST_GAP;
                    end
                end
                ST_GAP:  state <= ST_IDLE;
                default: begin
                    state     <= ST_IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mask8              = '0;
        pend8              = '0;
        mask8[NUM_SRC-1:0] = mask;
        pend8[NUM_SRC-1:0] = pend;
        case (port_id)
            ADDR_VEC:  rd_nxt = {valid, 4'b0000, vec};
            ADDR_MASK: rd_nxt = mask8;
            ADDR_PEND: rd_nxt = pend8;
            ADDR_TDIV: rd_nxt = tdiv;
            default:   rd_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 8'h00;
            rd_hit  <= 1'b0;
        end else begin
            rd_data <= rd_nxt;
            rd_hit  <= (port_id >= ADDR_VEC) && (port_id <= ADDR_TDIV);
        end
    end
endmodule

// File: tb/tb_pb_irq_ctrl.sv
// Purpose : self-checking bench for pb_irq_ctrl (NUM_SRC=4, TICK_PRE=4).
// Latency : reads are checked one cycle after port_id is driven, from a queue.
// Backpr. : n/a; honours IRQ_RR_EN for the arbitration sequence.
module tb_pb_irq_ctrl;
    localparam int NUM_SRC = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_SRC-2:0] src_evt;
    logic [7:0]         port_id, out_port, rd_data;
    logic               write_strobe, read_strobe, rd_hit, interrupt, interrupt_ack, tick;

    pb_irq_ctrl #(.NUM_SRC(NUM_SRC), .TICK_PRE(4), .TICK_DIV_RST(99)) dut (
        .clk(clk), .rst(rst), .src_evt(src_evt), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe), .rd_data(rd_data),
        .rd_hit(rd_hit), .interrupt(interrupt), .interrupt_ack(interrupt_ack), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dat;
        logic       hit;
    } rd_exp_t;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdat;
        logic [7:0] exp;
        logic       hit;
        string      nm;
    } vec_t;

    rd_exp_t exp_q[$];
    string   nm_q[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    vec_t    tbl[11];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
        end
    endtask

    task automatic check_read();
        rd_exp_t e;
        string   nm;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            chk({nm, "_dat"}, rd_data, e.dat);
            chk({nm, "_hit"}, {7'd0, rd_hit}, {7'd0, e.hit});
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input logic hit, input string nm);
        rd_exp_t e;
        e.dat = exp;
        e.hit = hit;
        port_id     = a;
        read_strobe = 1'b1;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        cyc();
        check_read();
        read_strobe = 1'b0;
        port_id     = 8'h00;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_id      = a;
        out_port     = d;
        write_strobe = 1'b1;
        cyc();
        write_strobe = 1'b0;
        port_id      = 8'h00;
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        cyc();
        interrupt_ack = 1'b0;
    endtask

    task automatic wait_irq(input string nm);
        int n;
        n = 0;
        while (!interrupt && n < 20) begin
            cyc();
            n++;
        end
        chk(nm, {7'd0, interrupt}, 8'h01);
    endtask

    task automatic count_tick(input string nm, input int start);
        int n;
        n = start;
        do begin
            cyc();
            n++;
        end while (!tick && n < 40);
        chk(nm, 8'(n), 8'd12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] rr_exp[4];
`ifdef IRQ_RR_EN
        rr_exp = '{3'd1, 3'd2, 3'd1, 3'd2};
`else
        rr_exp = '{3'd1, 3'd1, 3'd1, 3'd1};
`endif
        tbl[0]  = '{1'b0, 8'h11, 8'h00, 8'h01, 1'b1, "rst_mask"};
        tbl[1]  = '{1'b0, 8'h12, 8'h00, 8'h00, 1'b1, "rst_pend"};
        tbl[2]  = '{1'b0, 8'h13, 8'h00, 8'h63, 1'b1, "rst_tdiv"};
        tbl[3]  = '{1'b0, 8'h10, 8'h00, 8'h00, 1'b1, "rst_vec"};
        tbl[4]  = '{1'b1, 8'h13, 8'hFF, 8'h00, 1'b0, "wr_tdiv"};
        tbl[5]  = '{1'b0, 8'h13, 8'h00, 8'hFF, 1'b1, "tdiv_rw"};
        tbl[6]  = '{1'b0, 8'h20, 8'h00, 8'h00, 1'b0, "miss_addr"};
        tbl[7]  = '{1'b1, 8'h11, 8'hFF, 8'h00, 1'b0, "wr_mask_ff"};
        tbl[8]  = '{1'b0, 8'h11, 8'h00, 8'h0F, 1'b1, "mask_hi_bits"};
        tbl[9]  = '{1'b1, 8'h11, 8'hF0, 8'h00, 1'b0, "wr_mask_f0"};
        tbl[10] = '{1'b0, 8'h11, 8'h00, 8'h00, 1'b1, "mask_ign_hi"};

        rst = 1'b1; src_evt = '1; port_id = 8'h00; out_port = 8'h00;
        write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        chk("rst_irq",    {7'd0, interrupt}, 8'h00);
        chk("rst_tick",   {7'd0, tick},      8'h00);
        chk("rst_rd_hit", {7'd0, rd_hit},    8'h00);
        chk("rst_rd_dat", rd_data,           8'h00);
        // Lines high through reset must not register as edges.
        cyc();
        src_evt = '0;

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].wdat);
            else           rd(tbl[i].addr, tbl[i].exp, tbl[i].hit, tbl[i].nm);
        end
        rd(8'h12, 8'h00, 1'b1, "hi_src_no_evt");

        // Tick period with TICK_DIV=2: 12 cycles.
        wr(8'h12, 8'hFF);
        wr(8'h11, 8'h01);
        wr(8'h13, 8'h02);
        count_tick("tick_first", 0);
        chk("irq_before_pend", {7'd0, interrupt}, 8'h00);
        cyc();
        chk("irq_after_pend", {7'd0, interrupt}, 8'h01);
        count_tick("tick_period", 1);
        ack();
        chk("irq_ack_drop", {7'd0, interrupt}, 8'h00);
        rd(8'h10, 8'h80, 1'b1, "vec_tick");
        rd(8'h10, 8'h00, 1'b1, "vec_cleared");
        wr(8'h13, 8'hFF);
        wr(8'h12, 8'hFF);

        // Fixed/initial priority: sources 1 and 3 together.
        wr(8'h11, 8'h0F);
        src_evt = 3'b101;
        cyc();
        cyc();
        chk("prio_irq", {7'd0, interrupt}, 8'h01);
        rd(8'h12, 8'h0A, 1'b1, "prio_pend");
        ack();
        chk("prio_gap0", {7'd0, interrupt}, 8'h00);
        cyc();
        chk("prio_gap1", {7'd0, interrupt}, 8'h00);
        cyc();
        chk("prio_reassert", {7'd0, interrupt}, 8'h01);
        rd(8'h10, 8'h81, 1'b1, "prio_vec1");
        ack();
        rd(8'h10, 8'h83, 1'b1, "prio_vec3");
        rd(8'h12, 8'h00, 1'b1, "prio_pend_end");
        src_evt = 3'b000;

        // Masked pending, then mask enable, then W1C withdrawal.
        wr(8'h11, 8'h01);
        src_evt = 3'b010;
        repeat (4) cyc();
        chk("masked_no_irq", {7'd0, interrupt}, 8'h00);
        rd(8'h12, 8'h04, 1'b1, "masked_pend");
        wr(8'h11, 8'h05);
        cyc();
        chk("unmask_irq", {7'd0, interrupt}, 8'h01);
        wr(8'h12, 8'h04);
        cyc();
        chk("w1c_withdraw", {7'd0, interrupt}, 8'h00);
        repeat (2) cyc();
        chk("w1c_stays_low", {7'd0, interrupt}, 8'h00);
        ack();
        rd(8'h10, 8'h03, 1'b1, "idle_ack_ignored");
        src_evt = 3'b000;

        // Event on source 1 coinciding with the ack that clears it.
        wr(8'h11, 8'h0F);
        src_evt = 3'b001;
        cyc();
        src_evt = 3'b000;
        wait_irq("coll_irq");
        src_evt = 3'b001;
        ack();
        chk("coll_gap0", {7'd0, interrupt}, 8'h00);
        cyc();
        chk("coll_gap1", {7'd0, interrupt}, 8'h00);
        cyc();
        chk("coll_reassert", {7'd0, interrupt}, 8'h01);
        rd(8'h12, 8'h02, 1'b1, "coll_pend");
        rd(8'h10, 8'h81, 1'b1, "coll_vec");
        ack();
        src_evt = 3'b000;

        // Sources 1 and 2 kept pending across four acks.
        wr(8'h11, 8'h06);
        src_evt = 3'b011;
        cyc();
        for (int r = 0; r < 4; r++) begin
            wait_irq("arb_irq");
            interrupt_ack = 1'b1;
            src_evt       = 3'b000;
            cyc();
            interrupt_ack = 1'b0;
            src_evt       = 3'b011;
            cyc();
            rd(8'h10, {5'b10000, rr_exp[r]}, 1'b1, "arb_vec");
        end

        // Reset from REQ with lines held high.
        wait_irq("pre_rst_irq");
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_irq", {7'd0, interrupt}, 8'h00);
        chk("mid_rst_hit", {7'd0, rd_hit},    8'h00);
        rd(8'h12, 8'h00, 1'b1, "mid_rst_pend");
        rd(8'h11, 8'h01, 1'b1, "mid_rst_mask");
        rd(8'h13, 8'h63, 1'b1, "mid_rst_tdiv");
        rd(8'h10, 8'h00, 1'b1, "mid_rst_vec");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
